dm_access_ctrl: RTL and testbench
=================================

// Module: dm_access_ctrl
// PURPOSE
//  Load/store access controller in front of the 4 KB data memory (dm_4k).
//  Takes one CPU byte-addressed access at a time and drives dm_4k's word port
//  (addr[11:2], din, we), then returns load data sign- or zero-extended.
//  dm_4k has no byte enables, so sub-word stores are done as read-modify-write.
//  Flags misaligned, illegal-size and out-of-window accesses without touching memory.
// PARAMETERS
//  DM_AW      10            word-address width of dm_4k (1024 words)
//  BASE_ADDR  32'h0000_0000 window base; valid iff req_addr[31:DM_AW+2]==BASE_ADDR[31:DM_AW+2]
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   synchronous reset, active-high
//  req_valid     in   1   access request valid
//  req_ready     out  1   controller can accept (IDLE only)
//  req_we        in   1   1=store, 0=load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1   loads: 1=zero-extend, 0=sign-extend
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-aligned
//  resp_valid    out  1   response valid, held until resp_ready
//  resp_ready    in   1   consumer accepts response
//  resp_rdata    out  32  load result (0 for stores and errors)
//  resp_err      out  1   access rejected, no memory side effect
//  dm_addr       out  10  to dm_4k addr[11:2]
//  dm_din        out  32  to dm_4k datain
//  dm_we         out  1   to dm_4k memwr
//  dm_dout       in   32  from dm_4k dout; sampled at end of RD cycle
// BEHAVIOUR
//  Reset: state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, dm_we=0,
//   dm_addr=0, dm_din=0, req_ready=1 on the first cycle after rst drops.
//  States: IDLE, RD, WR, RESP. One outstanding access; no pipelining.
//  Accept on req_valid&&req_ready in IDLE; latch addr/wdata/size/we/unsigned.
//   dm_addr = latched addr[DM_AW+1:2], held stable until the next accept.
//  Error at accept: size==11, half with addr[0]!=0, word with addr[1:0]!=0,
//   or addr outside window -> IDLE->RESP, resp_err=1, rdata=0, no RD/WR.
//  Word store: IDLE->WR->RESP. WR: dm_din=wdata, dm_we=1 for exactly one cycle.
//  Load: IDLE->RD->RESP. dm_dout captured at RD's closing edge. Little-endian lanes:
//   byte lane addr[1:0], half lane addr[1]; extend to 32 per req_unsigned; word as-is.
//  Sub-word store: IDLE->RD->WR->RESP. WR writes the captured word with the
//   byte (wdata[7:0]) or half (wdata[15:0]) lane replaced; other lanes unchanged.
//  resp_valid first high N cycles after accept cycle: error 1, load 2,
//   word store 2, sub-word store 3.
//  RESP: resp_valid=1, rdata/err stable until resp_valid&&resp_ready; then IDLE
//   (resp_valid=0 next cycle). resp_ready high early completes on first RESP cycle.
//  dm_we=1 only in WR and is gated by !rst: no write occurs on any edge with rst=1.
//  rst in any state -> IDLE at that edge; in-flight access dropped, no response.
//  req_ready=0 in RD/WR/RESP regardless of req_valid.
// TESTING
//  1 rst high 2 cycles, then low -> req_ready=1, resp_valid=0, dm_we never asserted.
//  2 sw 0x004<=0x00000001, then lw 0x004 -> one dm_we pulse, dm_addr=1, dm_din=1;
//    resp_rdata=0x00000001, resp_valid 2 cycles after each accept.
//  3 sw 0x008<=0x00000067; sb 0x00B<=0xAB -> word2=0xAB000067 (3-cycle latency);
//    lb 0x00B -> 0xFFFFFFAB; lbu 0x00B -> 0x000000AB.
//  4 sh 0x00A<=0x8001 -> word2=0x80010067; lh 0x00A -> 0xFFFF8001; lhu -> 0x00008001.
//  5 lw 0x006, sh 0x009, size=11, lw 0x1000 -> resp_err=1 after 1 cycle, rdata=0, dm_we=0.
//  6 hold resp_ready=0 3 cycles -> resp_valid/rdata stable, req_ready=0;
//    rst=1 while in WR -> no dm_we on that edge, IDLE next cycle, no resp.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// Load/store access controller for the dm_4k word memory.
// Sub-word stores are done as read-modify-write because dm_4k has no byte enables.
//
// state | meaning
// IDLE  | ready for a new access, req_ready=1
// RD    | word read from dm_4k; dout captured on the closing edge
// WR    | single-cycle write of the full or merged word (dm_we=1)
// RESP  | response held until resp_ready
module dm_access_ctrl #(
  parameter int          DM_AW     = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_din,
  output logic             dm_we,
  input  logic [31:0]      dm_dout
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic [15:0] wdata_q;
  logic        we_r;
  logic        acc_err;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [15:0] d,
                                        input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] r;
    r = w;
    if (size == SZ_BYTE) begin
      case (lane)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = d;
    end else begin
      r[15:0] = d;
    end
    return r;
  endfunction

  always_comb begin
    acc_err = 1'b0;
    if (req_size == 2'b11)                               acc_err = 1'b1;
    if (req_size == SZ_HALF && req_addr[0] != 1'b0)      acc_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)   acc_err = 1'b1;
    if (req_addr[31:DM_AW+2] != BASE_ADDR[31:DM_AW+2])   acc_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      dm_addr    <= '0;
      dm_din     <= '0;
      we_r       <= 1'b0;
      lane_q     <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lane_q     <= req_addr[1:0];
            size_q     <= req_size;
            we_q       <= req_we;
            uns_q      <= req_unsigned;
            wdata_q    <= req_wdata[15:0];
            dm_addr    <= req_addr[DM_AW+1:2];
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            if (acc_err) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (req_we && req_size == SZ_WORD) begin
              resp_err <= 1'b0;
              dm_din   <= req_wdata;
              we_r     <= 1'b1;
              state    <= WR;
            end else begin
              resp_err <= 1'b0;
              state    <= RD;
            end
          end
        end
        RD: begin
          // dm_addr has been stable since accept, so dm_dout is valid here
          if (we_q) begin
            dm_din <= merge(dm_dout, wdata_q, lane_q, size_q);
            we_r   <= 1'b1;
            state  <= WR;
          end else begin
            resp_rdata <= load_ext(dm_dout, lane_q, size_q, uns_q);
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WR: begin
          we_r       <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gating by rst keeps a reset edge that lands in WR from writing memory
  assign dm_we = we_r & ~rst;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed self-checking bench for dm_access_ctrl with a behavioural dm_4k model.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din, dm_dout;
  logic        dm_we;

  logic [31:0] mem [0:1023];
  int          we_count = 0;
  logic [9:0]  last_we_addr;
  logic [31:0] last_we_din;
  int          checks = 0;
  int          errors = 0;

  dm_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dm_addr(dm_addr),
    .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  assign dm_dout = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_we) begin
      mem[dm_addr] <= dm_din;
      we_count     = we_count + 1;
      last_we_addr = dm_addr;
      last_we_din  = dm_din;
    end
  end

  // Drives one access with resp_ready high; returns cycles from accept to resp_valid (10 = timeout).
  task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err,
                           output int lat, output int wes);
    int n;
    int w0;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    w0           = we_count;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    resp_ready   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin @(negedge clk); lat++; end
    rdata = resp_rdata;
    err   = resp_err;
    @(posedge clk);
    @(negedge clk);
    wes = we_count - w0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    checks++; if (resp_err !== 1'b0 || resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp got err=%b rdata=%h exp 0/0", resp_err, resp_rdata); end
    checks++; if (dm_addr !== 10'h0 || dm_din !== 32'h0) begin errors++; $display("FAIL reset_dm got addr=%h din=%h exp 0/0", dm_addr, dm_din); end
    checks++; if (we_count !== 0) begin errors++; $display("FAIL reset_no_we got %0d exp 0", we_count); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat, wes;
    do_access(1'b1, 2'b10, 1'b0, 32'h004, 32'h0000_0001, rd, er, lat, wes);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency got %0d exp 2", lat); end
    checks++; if (wes !== 1) begin errors++; $display("FAIL sw_we_pulses got %0d exp 1", wes); end
    checks++; if (last_we_addr !== 10'd1 || last_we_din !== 32'h1) begin errors++; $display("FAIL sw_dm_port got addr=%h din=%h exp 1/00000001", last_we_addr, last_we_din); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sw_resp got err=%b rdata=%h exp 0/0", er, rd); end
    do_access(1'b0, 2'b10, 1'b0, 32'h004, 32'h0, rd, er, lat, wes);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got %0d exp 2", lat); end
    checks++; if (rd !== 32'h0000_0001 || er !== 1'b0) begin errors++; $display("FAIL lw_rdata got %h err=%b exp 00000001/0", rd, er); end
    checks++; if (wes !== 0) begin errors++; $display("FAIL lw_no_we got %0d exp 0", wes); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat, wes;
    do_access(1'b1, 2'b10, 1'b0, 32'h008, 32'h0000_0067, rd, er, lat, wes);
    do_access(1'b1, 2'b00, 1'b0, 32'h00B, 32'h0000_00AB, rd, er, lat, wes);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency got %0d exp 3", lat); end
    checks++; if (wes !== 1) begin errors++; $display("FAIL sb_we_pulses got %0d exp 1", wes); end
    checks++; if (mem[2] !== 32'hAB00_0067) begin errors++; $display("FAIL sb_word got %h exp AB000067", mem[2]); end
    do_access(1'b0, 2'b00, 1'b0, 32'h00B, 32'h0, rd, er, lat, wes);
    checks++; if (rd !== 32'hFFFF_FFAB || lat !== 2) begin errors++; $display("FAIL lb got %h lat=%0d exp FFFFFFAB/2", rd, lat); end
    do_access(1'b0, 2'b00, 1'b1, 32'h00B, 32'h0, rd, er, lat, wes);
    checks++; if (rd !== 32'h0000_00AB) begin errors++; $display("FAIL lbu got %h exp 000000AB", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat, wes;
    do_access(1'b1, 2'b01, 1'b0, 32'h00A, 32'hFFFF_8001, rd, er, lat, wes);
    checks++; if (lat !== 3 || wes !== 1) begin errors++; $display("FAIL sh_timing got lat=%0d we=%0d exp 3/1", lat, wes); end
    checks++; if (mem[2] !== 32'h8001_0067) begin errors++; $display("FAIL sh_word got %h exp 80010067", mem[2]); end
    do_access(1'b0, 2'b01, 1'b0, 32'h00A, 32'h0, rd, er, lat, wes);
    checks++; if (rd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh got %h exp FFFF8001", rd); end
    do_access(1'b0, 2'b01, 1'b1, 32'h00A, 32'h0, rd, er, lat, wes);
    checks++; if (rd !== 32'h0000_8001) begin errors++; $display("FAIL lhu got %h exp 00008001", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat, wes;
    logic        e_we   [4];
    logic [1:0]  e_size [4];
    logic [31:0] e_addr [4];
    logic [31:0] snap2, snap3;
    e_we[0] = 1'b0; e_size[0] = 2'b10; e_addr[0] = 32'h0000_0006;
    e_we[1] = 1'b1; e_size[1] = 2'b01; e_addr[1] = 32'h0000_0009;
    e_we[2] = 1'b1; e_size[2] = 2'b11; e_addr[2] = 32'h0000_0008;
    e_we[3] = 1'b0; e_size[3] = 2'b10; e_addr[3] = 32'h0000_1000;
    snap2 = mem[2];
    snap3 = mem[3];
    for (int i = 0; i < 4; i++) begin
      do_access(e_we[i], e_size[i], 1'b0, e_addr[i], 32'hFFFF_FFFF, rd, er, lat, wes);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || wes !== 0) begin
        errors++;
        $display("FAIL err_case%0d got err=%b rdata=%h lat=%0d we=%0d exp 1/0/1/0", i, er, rd, lat, wes);
      end
    end
    checks++; if (mem[2] !== snap2 || mem[3] !== snap3) begin errors++; $display("FAIL err_mem_untouched got %h %h exp %h %h", mem[2], mem[3], snap2, snap3); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat, wes;
    do_access(1'b1, 2'b01, 1'b0, 32'h00E, 32'h0000_1234, rd, er, lat, wes);
    do_access(1'b1, 2'b00, 1'b0, 32'h00D, 32'h0000_0080, rd, er, lat, wes);
    do_access(1'b0, 2'b01, 1'b1, 32'h00E, 32'h0, rd, er, lat, wes);
    checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL b2b_lhu got %h exp 00001234", rd); end
    do_access(1'b0, 2'b00, 1'b0, 32'h00D, 32'h0, rd, er, lat, wes);
    checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL b2b_lb got %h exp FFFFFF80", rd); end
    do_access(1'b0, 2'b10, 1'b0, 32'h00C, 32'h0, rd, er, lat, wes);
    checks++; if (rd !== 32'h1234_8000) begin errors++; $display("FAIL b2b_lw got %h exp 12348000", rd); end
  endtask

  task automatic test_backpressure();
    int n;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h008; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 10) begin @(negedge clk); n++; end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h8001_0067 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d got valid=%b rdata=%h ready=%b exp 1/80010067/0", i, resp_valid, resp_rdata, req_ready);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL hold_release got valid=%b ready=%b exp 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_reset_in_wr();
    int w0;
    w0 = we_count;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h010; req_wdata = 32'hDEAD_BEEF; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (we_count !== w0 || mem[4] !== 32'h0) begin errors++; $display("FAIL rst_wr_no_write got we=%0d mem=%h exp %0d/00000000", we_count, mem[4], w0); end
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL rst_wr_idle got ready=%b valid=%b exp 1/0", req_ready, resp_valid); end
    repeat (3) @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || we_count !== w0) begin errors++; $display("FAIL rst_wr_no_resp got valid=%b we=%0d exp 0/%0d", resp_valid, we_count, w0); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_reset_in_wr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
